mcpu_ctrl_fsm: RTL and testbench
================================

Name: mcpu_ctrl_fsm

Overview:
- Multi-cycle control unit for the MCPU datapath.
- Sequences each RV32I-subset instruction through fetch, decode, execute, memory and writeback states.
- Drives the PC register's write enable (PC_Write_Final) and next-PC select, plus instruction register, memory, ALU and register-file controls.
- Handles variable-latency memory through a ready handshake, and keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (instr_count); wraps modulo 2^CNT_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- opcode  in  7  instruction[6:0] from the instruction register.
- br_taken  in  1  branch condition from the datapath comparator, already resolved per funct3.
- mem_ready  in  1  memory access completes this cycle.
- stall  in  1  external hold; sampled only in S_IF.
- PC_Write_Final  out  1  PC register write enable.
- PCSource  out  1  0 = ALU result, 1 = ALUOut register.
- IRWrite  out  1  instruction register load.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- RegWrite  out  1  register-file write.
- WDSel  out  2  write-data select: 0 = ALUOut, 1 = MDR, 2 = PC, 3 = imm.
- ALUSrcA  out  2  ALU A select: 0 = PC, 1 = rs1 (reg A), 2 = OldPC.
- ALUSrcB  out  2  ALU B select: 0 = rs2 (reg B), 1 = constant 4, 2 = imm.
- ALUOp  out  2  0 = add, 1 = compare/sub, 2 = funct-decoded.
- state  out  4  current state encoding, for debug.
- illegal  out  1  sticky: an undecoded opcode has been seen.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset
  - While rst=0: state = S_IF (0), illegal = 0, instr_count = 0.
  - While rst=0: every control output is forced to 0, including MemRead in S_IF.
  - A reset asserted mid-instruction aborts that instruction immediately; nothing is retired.
- Output style and state encodings
  - Control outputs are Moore-decoded from state, with the exceptions noted below: mem_ready gating in S_IF/S_MEMRD/S_MEMWR, and br_taken in S_BRANCH.
  - Any control output not listed for a state is 0.
  - Encodings: S_IF=0, S_ID=1, S_MEMADR=2, S_MEMRD=3, S_MEMWB=4, S_MEMWR=5, S_EXE_R=6, S_EXE_I=7, S_ALUWB=8, S_BRANCH=9, S_JAL=10, S_JALR=11, S_LUI=12.
  - Codes 13-15 go to S_IF on the next clock, with all outputs 0.
- S_IF
  - If stall=1: all outputs 0; remain in S_IF.
  - Otherwise: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0.
  - IRWrite, PC_Write_Final and PCSource=0 are asserted only in the cycle mem_ready=1; then go to S_ID.
  - If mem_ready=0: hold in S_IF, no PC or IR write.
- S_ID
  - ALUSrcA=2, ALUSrcB=2, ALUOp=0, so ALUOut = branch/JAL target.
  - Dispatch on opcode:
    - 0000011 or 0100011 -> S_MEMADR
    - 0110011 -> S_EXE_R
    - 0010011 -> S_EXE_I
    - 1100011 -> S_BRANCH
    - 1101111 -> S_JAL
    - 1100111 -> S_JALR
    - 0110111 -> S_LUI
    - any other opcode -> set illegal; go to S_IF (not retired).
- S_MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Load -> S_MEMRD; store -> S_MEMWR.
- S_MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then go to S_MEMWB.
- S_MEMWB: RegWrite=1, WDSel=1; go to S_IF (retire).
- S_MEMWR: MemWrite=1, IorD=1. Wait for mem_ready, then go to S_IF (retire in that cycle).
- S_EXE_R: ALUSrcA=1, ALUSrcB=0, ALUOp=2; go to S_ALUWB.
- S_EXE_I: ALUSrcA=1, ALUSrcB=2, ALUOp=2; go to S_ALUWB.
- S_ALUWB: RegWrite=1, WDSel=0; go to S_IF (retire).
- S_BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSource=1, PC_Write_Final=br_taken; go to S_IF (retire).
- S_JAL: PC_Write_Final=1, PCSource=1, RegWrite=1, WDSel=2; go to S_IF (retire). The link value is PC, which already holds PC+4.
- S_JALR: ALUSrcA=1, ALUSrcB=2, ALUOp=0, PCSource=0, PC_Write_Final=1, RegWrite=1, WDSel=2; go to S_IF (retire).
- S_LUI: RegWrite=1, WDSel=3; go to S_IF (retire).
- Retirement counting: instr_count increments by 1 on every clock edge that moves into S_IF from a retiring state; it wraps from all-ones to 0.
- Latencies with mem_ready tied to 1:
  - R-type, I-type, load-word address, JAL, JALR, LUI and branch paths: 3-4 cycles.
  - R/I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch, JAL, JALR, LUI: 3 cycles.
  - Each mem_ready=0 cycle in S_IF/S_MEMRD/S_MEMWR adds exactly one cycle.

Test Plan:
- Reset, then release with mem_ready=1 and opcode=0110011 -> state sequence 0,1,6,8,0. PC_Write_Final=1 only in the first S_IF cycle. RegWrite=1 only in S_ALUWB. instr_count=1.
- Load (0000011) with mem_ready low for 2 cycles in S_MEMRD -> states 0,1,2,3,3,3,4,0. MemRead/IorD=1 held for 3 cycles. No RegWrite before S_MEMWB.
- Branch with br_taken=0, then br_taken=1 -> PC_Write_Final=0, then 1 with PCSource=1, in S_BRANCH. Both are retired: instr_count +2.
- opcode=1111111 -> illegal=1 after S_ID; returns to S_IF; instr_count unchanged. illegal stays 1 through a following valid instruction, until rst=0.
- stall=1 for 3 cycles in S_IF, plus rst pulsed low while in S_MEMWR -> no MemRead/PC write while stalled. Reset forces state=0 and all outputs 0 asynchronously, and instr_count=0.
- CNT_W=4: retire 16 LUI instructions -> instr_count wraps from 15 to 0.

Source files
------------

// File: rtl/mcpu_ctrl_fsm.sv
// mcpu_ctrl_fsm: multi-cycle control sequencer for the MCPU datapath, with
// memory ready handshake, retired-instruction counter and sticky illegal flag.
module mcpu_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             mem_ready,
  input  logic             stall,
  output logic             PC_Write_Final,
  output logic             PCSource,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       WDSel,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    S_IF, S_ID, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXE_R,
    S_EXE_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI
  } state_t;
  state_t st, nx;
  logic retire, bad;
  logic pcw, pcs, irw, iord, mrd, mwr, rw;
  logic [1:0] wd, asa, asb, aop;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= S_IF;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      st <= nx;
      if (bad) illegal <= 1'b1;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end
  always_comb begin
    nx     = S_IF;
    retire = 1'b0;
    bad    = 1'b0;
    pcw    = 1'b0;
    pcs    = 1'b0;
    irw    = 1'b0;
    iord   = 1'b0;
    mrd    = 1'b0;
    mwr    = 1'b0;
    rw     = 1'b0;
    wd     = 2'd0;
    asa    = 2'd0;
    asb    = 2'd0;
    aop    = 2'd0;
    case (st)
      S_IF: if (!stall) begin
        mrd = 1'b1;
        asb = 2'd1;
        irw = mem_ready;
        pcw = mem_ready;
        nx  = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        asa = 2'd2;
        asb = 2'd2;
        case (opcode)
          7'b0000011, 7'b0100011: nx = S_MEMADR;
          7'b0110011: nx = S_EXE_R;
          7'b0010011: nx = S_EXE_I;
          7'b1100011: nx = S_BRANCH;
          7'b1101111: nx = S_JAL;
          7'b1100111: nx = S_JALR;
          7'b0110111: nx = S_LUI;
          default:    bad = 1'b1;
        endcase
      end
      S_MEMADR: begin
        asa = 2'd1;
        asb = 2'd2;
        nx  = (opcode == 7'b0000011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mrd  = 1'b1;
        iord = 1'b1;
        nx   = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        rw     = 1'b1;
        wd     = 2'd1;
        retire = 1'b1;
      end
      S_MEMWR: begin
        mwr    = 1'b1;
        iord   = 1'b1;
        nx     = mem_ready ? S_IF : S_MEMWR;
        retire = mem_ready;
      end
      S_EXE_R: begin
        asa = 2'd1;
        aop = 2'd2;
        nx  = S_ALUWB;
      end
      S_EXE_I: begin
        asa = 2'd1;
        asb = 2'd2;
        aop = 2'd2;
        nx  = S_ALUWB;
      end
      S_ALUWB: begin
        rw     = 1'b1;
        retire = 1'b1;
      end
      S_BRANCH: begin
        asa    = 2'd1;
        aop    = 2'd1;
        pcs    = 1'b1;
        pcw    = br_taken;
        retire = 1'b1;
      end
      S_JAL: begin
        pcw    = 1'b1;
        pcs    = 1'b1;
        rw     = 1'b1;
        wd     = 2'd2;
        retire = 1'b1;
      end
      S_JALR: begin
        asa    = 2'd1;
        asb    = 2'd2;
        pcw    = 1'b1;
        rw     = 1'b1;
        wd     = 2'd2;
        retire = 1'b1;
      end
      S_LUI: begin
        rw     = 1'b1;
        wd     = 2'd3;
        retire = 1'b1;
      end
      default: ;
    endcase
  end
  // reset must silence the Moore decode immediately, including the S_IF fetch read
  assign PC_Write_Final = rst & pcw;
  assign PCSource       = rst & pcs;
  assign IRWrite        = rst & irw;
  assign IorD           = rst & iord;
  assign MemRead        = rst & mrd;
  assign MemWrite       = rst & mwr;
  assign RegWrite       = rst & rw;
  assign WDSel          = rst ? wd  : 2'd0;
  assign ALUSrcA        = rst ? asa : 2'd0;
  assign ALUSrcB        = rst ? asb : 2'd0;
  assign ALUOp          = rst ? aop : 2'd0;
  assign state          = st;
endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// tb_mcpu_ctrl_fsm: table vectors, hand sequences and a random run against
// an instruction-path reference model for mcpu_ctrl_fsm.
module tb_mcpu_ctrl_fsm;
  localparam logic [6:0] OL = 7'b0000011, OS = 7'b0100011, OR = 7'b0110011,
                         OI = 7'b0010011, OB = 7'b1100011, OJ = 7'b1101111,
                         OJR = 7'b1100111, OU = 7'b0110111, OX = 7'b1111111;
  logic clk = 1'b0, rst = 1'b0;
  logic [6:0] opcode = '0;
  logic br_taken = 1'b0, mem_ready = 1'b0, stall = 1'b0;
  logic pcw, pcs, irw, iord, mrd, mwr, rw, ill;
  logic [1:0] wd, asa, asb, aop;
  logic [3:0] state;
  logic [31:0] cnt;
  logic pcw4, pcs4, irw4, iord4, mrd4, mwr4, rw4, ill4;
  logic [1:0] wd4, asa4, asb4, aop4;
  logic [3:0] state4, cnt4;
  logic [14:0] outs, outs4;
  int checks = 0, errors = 0;
  int m_state, m_plan[$];
  bit m_ill;
  int unsigned m_cnt;
  logic [6:0] cur_op;
  typedef struct {
    bit stl, mr, bt;
    logic [6:0] op;
    int st;
    bit pcw, mrd, rw, ill;
    int cnt;
  } vec_t;
  vec_t tbl[25];

  mcpu_ctrl_fsm #(.CNT_W(32)) u32 (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
    .stall(stall), .PC_Write_Final(pcw), .PCSource(pcs), .IRWrite(irw), .IorD(iord),
    .MemRead(mrd), .MemWrite(mwr), .RegWrite(rw), .WDSel(wd), .ALUSrcA(asa),
    .ALUSrcB(asb), .ALUOp(aop), .state(state), .illegal(ill), .instr_count(cnt));
  mcpu_ctrl_fsm #(.CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
    .stall(stall), .PC_Write_Final(pcw4), .PCSource(pcs4), .IRWrite(irw4), .IorD(iord4),
    .MemRead(mrd4), .MemWrite(mwr4), .RegWrite(rw4), .WDSel(wd4), .ALUSrcA(asa4),
    .ALUSrcB(asb4), .ALUOp(aop4), .state(state4), .illegal(ill4), .instr_count(cnt4));

  assign outs  = {pcw, pcs, irw, iord, mrd, mwr, rw, wd, asa, asb, aop};
  assign outs4 = {pcw4, pcs4, irw4, iord4, mrd4, mwr4, rw4, wd4, asa4, asb4, aop4};
  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  // Expected control word, built signal by signal from the per-state rules.
  function automatic logic [14:0] exp_outs(int s, bit stl, bit mr, bit bt);
    bit fetch = (s == 0) && !stl;
    bit e_pcw = (fetch && mr) || (s == 9 && bt) || s == 10 || s == 11;
    bit e_pcs = s == 9 || s == 10;
    bit e_irw = fetch && mr;
    bit e_iord = s == 3 || s == 5;
    bit e_mrd = fetch || s == 3;
    bit e_mwr = s == 5;
    bit e_rw = s inside {4, 8, 10, 11, 12};
    logic [1:0] e_wd = s == 4 ? 2'd1 : (s == 10 || s == 11) ? 2'd2 : s == 12 ? 2'd3 : 2'd0;
    logic [1:0] e_a = s == 1 ? 2'd2 : (s inside {2, 6, 7, 9, 11}) ? 2'd1 : 2'd0;
    logic [1:0] e_b = fetch ? 2'd1 : (s inside {1, 2, 7, 11}) ? 2'd2 : 2'd0;
    logic [1:0] e_op = (s inside {6, 7}) ? 2'd2 : s == 9 ? 2'd1 : 2'd0;
    return {e_pcw, e_pcs, e_irw, e_iord, e_mrd, e_mwr, e_rw, e_wd, e_a, e_b, e_op};
  endfunction

  // Model: decode plans the remaining path; an emptied plan retires the instruction.
  task automatic model_adv(bit stl, bit mr, logic [6:0] op);
    if (m_state == 0) begin
      if (!stl && mr) m_state = 1;
    end else if (m_state == 1) begin
      case (op)
        OL: m_plan = {2, 3, 4};
        OS: m_plan = {2, 5};
        OR: m_plan = {6, 8};
        OI: m_plan = {7, 8};
        OB: m_plan = {9};
        OJ: m_plan = {10};
        OJR: m_plan = {11};
        OU: m_plan = {12};
        default: m_plan = {};
      endcase
      if (m_plan.size() == 0) begin
        m_ill = 1'b1;
        m_state = 0;
      end else m_state = m_plan.pop_front();
    end else if ((m_state == 3 || m_state == 5) && !mr) begin
    end else if (m_plan.size() != 0) m_state = m_plan.pop_front();
    else begin
      m_state = 0;
      m_cnt++;
    end
  endtask

  task automatic step(bit stl, bit mr, bit bt, logic [6:0] op);
    stall = stl; mem_ready = mr; br_taken = bt; opcode = op;
    #1;
    chk("rnd state", 32'(state), 32'(m_state));
    chk("rnd outs", 32'(outs), 32'(exp_outs(m_state, stl, mr, bt)));
    chk("rnd outs4", 32'(outs4), 32'(exp_outs(m_state, stl, mr, bt)));
    chk("rnd illegal", 32'(ill), 32'(m_ill));
    chk("rnd cnt32", cnt, m_cnt);
    chk("rnd cnt4", 32'(cnt4), m_cnt % 16);
    model_adv(stl, mr, op);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{0, 1, 0, OR, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, OR, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, OR, 6, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, OR, 8, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, OL, 0, 1, 1, 0, 0, 1};
    tbl[5]  = '{0, 1, 0, OL, 1, 0, 0, 0, 0, 1};
    tbl[6]  = '{0, 1, 0, OL, 2, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, OL, 3, 0, 1, 0, 0, 1};
    tbl[8]  = '{0, 0, 0, OL, 3, 0, 1, 0, 0, 1};
    tbl[9]  = '{0, 1, 0, OL, 3, 0, 1, 0, 0, 1};
    tbl[10] = '{0, 1, 0, OL, 4, 0, 0, 1, 0, 1};
    tbl[11] = '{0, 1, 0, OB, 0, 1, 1, 0, 0, 2};
    tbl[12] = '{0, 1, 0, OB, 1, 0, 0, 0, 0, 2};
    tbl[13] = '{0, 1, 0, OB, 9, 0, 0, 0, 0, 2};
    tbl[14] = '{0, 1, 1, OB, 0, 1, 1, 0, 0, 3};
    tbl[15] = '{0, 1, 1, OB, 1, 0, 0, 0, 0, 3};
    tbl[16] = '{0, 1, 1, OB, 9, 1, 0, 0, 0, 3};
    tbl[17] = '{0, 1, 0, OX, 0, 1, 1, 0, 0, 4};
    tbl[18] = '{0, 1, 0, OX, 1, 0, 0, 0, 0, 4};
    tbl[19] = '{0, 1, 0, OU, 0, 1, 1, 0, 1, 4};
    tbl[20] = '{0, 1, 0, OU, 1, 0, 0, 0, 1, 4};
    tbl[21] = '{0, 1, 0, OU, 12, 0, 0, 1, 1, 4};
    tbl[22] = '{1, 1, 0, OU, 0, 0, 0, 0, 1, 5};
    tbl[23] = '{1, 1, 0, OU, 0, 0, 0, 0, 1, 5};
    tbl[24] = '{1, 1, 0, OU, 0, 0, 0, 0, 1, 5};

    // Reset held: fetch read must stay off even with ready high.
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("reset state", 32'(state), 0);
    chk("reset outs", 32'(outs), 0);
    chk("reset cnt", cnt, 0);
    chk("reset illegal", 32'(ill), 0);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      stall = tbl[i].stl; mem_ready = tbl[i].mr; br_taken = tbl[i].bt; opcode = tbl[i].op;
      #1;
      chk($sformatf("tbl%0d state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d pcw", i), 32'(pcw), 32'(tbl[i].pcw));
      chk($sformatf("tbl%0d memread", i), 32'(mrd), 32'(tbl[i].mrd));
      chk($sformatf("tbl%0d regwrite", i), 32'(rw), 32'(tbl[i].rw));
      chk($sformatf("tbl%0d illegal", i), 32'(ill), 32'(tbl[i].ill));
      chk($sformatf("tbl%0d cnt", i), cnt, tbl[i].cnt);
      if (tbl[i].st == 9) chk($sformatf("tbl%0d pcsource", i), 32'(pcs), 1);
      @(posedge clk);
      @(negedge clk);
    end

    // Store aborted by an asynchronous reset while waiting in S_MEMWR.
    stall = 1'b0; mem_ready = 1'b1; br_taken = 1'b0; opcode = OS;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("memwr state", 32'(state), 5);
    chk("memwr write", 32'(mwr), 1);
    chk("memwr cnt", cnt, 5);
    #1 rst = 1'b0;
    #1;
    chk("async rst state", 32'(state), 0);
    chk("async rst outs", 32'(outs), 0);
    chk("async rst cnt", cnt, 0);
    chk("async rst illegal", 32'(ill), 0);
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst hold memread", 32'(mrd), 0);
    chk("rst hold state", 32'(state), 0);
    rst = 1'b1;

    // Sixteen LUIs: the 4-bit counter must wrap from 15 to 0.
    opcode = OU;
    for (int i = 0; i < 16; i++) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (i == 14) chk("lui cnt4 at 15", 32'(cnt4), 15);
    end
    chk("lui cnt4 wrap", 32'(cnt4), 0);
    chk("lui cnt32", cnt, 16);

    // Randomized run against the reference model.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_state = 0; m_plan = {}; m_ill = 1'b0; m_cnt = 0; cur_op = OR;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 0) begin
        case ($urandom_range(0, 9))
          0: cur_op = OL;
          1: cur_op = OS;
          2: cur_op = OR;
          3: cur_op = OI;
          4: cur_op = OB;
          5: cur_op = OJ;
          6: cur_op = OJR;
          7: cur_op = OU;
          8: cur_op = OX;
          default: cur_op = 7'($urandom);
        endcase
      end
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 1'($urandom), cur_op);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
